// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM driver.
// Counter widths, period limit and duty type.
package pwm_pkg;

  localparam int CNT_W = 8;
  localparam int PRE_W = 16;
  localparam int DT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'd254;

  typedef logic [7:0] duty_t;

  function automatic logic cnt_at_max(
    input logic [CNT_W-1:0] c
  );
    return c == CNT_MAX;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter for a complementary PWM pair.
// Ports: clk, rst, enable, raw in; pwm_hi, pwm_lo out.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [DT_W-1:0] DEAD_V = DT_W'(DEAD);

  logic            raw_q, raw_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  always_comb begin
    raw_d = 1'b0;
    dt_d  = DEAD_V;
    hi_d  = 1'b0;
    lo_d  = 1'b0;
    if (enable) begin
      raw_d = raw;
      if (raw != raw_q) begin
        dt_d = DEAD_V;
      end else if (dt_q != '0) begin
        dt_d = dt_q - DT_W'(1);
      end else begin
        dt_d = '0;
      end
      // Both sides derive from one bit, so they
      // can never be high together.
      hi_d = (dt_d == '0) & raw_d;
      lo_d = (dt_d == '0) & ~raw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      dt_q  <= DEAD_V;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      raw_q <= raw_d;
      dt_q  <= dt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pwm_driver.sv
// Double-buffered complementary PWM driver.
// Ports: clk, rst, enable, duty, duty_valid in;
// pwm_hi, pwm_lo, period_tick, duty_active out.
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int DEAD     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] duty,
  input  logic       duty_valid,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_tick,
  output logic [7:0] duty_active
);

  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(PRESCALE - 1);

  logic             en_q, en_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  duty_t            pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  duty_t            active_q, active_d;
  logic             pt_q, pt_d;

  logic start;
  logic run;
  logic tick;
  logic wrap;
  logic boundary;
  logic raw;

  // The first enabled cycle is a boundary but
  // holds the counters at 0; counting begins
  // the cycle after.
  assign start    = enable & ~en_q;
  assign run      = enable & en_q;
  assign tick     = (pre_cnt_q == PRE_MAX);
  assign wrap     = run & tick & cnt_at_max(cnt_q);
  assign boundary = start | wrap;
  assign raw      = run & (cnt_q < active_q);

  always_comb begin
    en_d      = enable;
    pre_cnt_d = '0;
    cnt_d     = '0;
    if (run) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (cnt_at_max(cnt_q)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        cnt_d     = cnt_q;
      end
    end
  end

  always_comb begin
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    active_d    = active_q;
    pt_d        = boundary;
    if (boundary) begin
      // A write landing on the boundary bypasses
      // the pending buffer.
      if (duty_valid) begin
        active_d    = duty;
        pending_d   = duty;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        active_d    = pending_q;
        pend_flag_d = 1'b0;
      end
    end else if (duty_valid) begin
      pending_d   = duty;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      active_q    <= '0;
      pt_q        <= 1'b0;
    end else begin
      en_q        <= en_d;
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      active_q    <= active_d;
      pt_q        <= pt_d;
    end
  end

  pwm_deadtime #(
    .DEAD(DEAD)
  ) u_dt (
    .clk   (clk),
    .rst   (rst),
    .enable(run),
    .raw   (raw),
    .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo)
  );

  assign period_tick = pt_q;
  assign duty_active = active_q;

endmodule
